// File: rtl/proc_num_seg_display.sv
// Sequential binary-to-seven-segment driver: converts a held process number to BCD
// one bit per clock (double-dabble) and shows it on active-low digits with blanking.
module proc_num_seg_display #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    single_clk,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   proc_num,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    function automatic logic [63:0] max_shown_calc(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_SHOWN = max_shown_calc(NUM_DIGITS);

    function automatic logic [7*NUM_DIGITS-1:0] seg_reset_calc();
        logic [7*NUM_DIGITS-1:0] s;
        s = '1;
        s[6:0] = 7'b1000000;
        return s;
    endfunction

    localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = seg_reset_calc();

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b0111111;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shown_val, bin_sr, cap_val, bin_next;
    logic [BCD_W-1:0]        bcd_sr, bcd_adj, bcd_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [7*NUM_DIGITS-1:0] seg_next;
    logic                    ovf_next;
    logic                    seen_nonzero;

    always_ff @(posedge single_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (proc_num != shown_val) state_next = SHIFT;
            SHIFT:   if (bit_cnt == LAST_CNT) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Add-3 correction precedes the shift so each nibble stays a valid decimal digit.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], bin_sr[DATA_WIDTH-1]};
        bin_next = {bin_sr[DATA_WIDTH-2:0], 1'b0};
    end

    // Overflow uses the full captured operand because the BCD accumulator truncates.
    always_comb begin
        ovf_next     = (64'(cap_val) > MAX_SHOWN);
        seg_next     = '1;
        seen_nonzero = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (bcd_sr[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
            if (ovf_next)
                seg_next[7*i +: 7] = 7'b0111111;
            else if (seen_nonzero || i == 0)
                seg_next[7*i +: 7] = seg_of(bcd_sr[4*i +: 4]);
        end
    end

    always_ff @(posedge single_clk or negedge reset_n) begin
        if (!reset_n) begin
            shown_val <= '0;
            cap_val   <= '0;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            bit_cnt   <= '0;
            seg_out   <= SEG_RESET;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (proc_num != shown_val) begin
                        bin_sr  <= proc_num;
                        cap_val <= proc_num;
                        bcd_sr  <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd_sr  <= bcd_next;
                    bin_sr  <= bin_next;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                UPDATE: begin
                    seg_out   <= seg_next;
                    shown_val <= cap_val;
                    overflow  <= ovf_next;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_num_seg_display.sv
// Directed bench for proc_num_seg_display: hand-computed segment patterns, busy
// lengths and done pulse timing for a series of process numbers.
module tb_proc_num_seg_display;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, BL = 7'b1111111, DS = 7'b0111111;

    logic        single_clk;
    logic        reset_n;
    logic [31:0] proc_num;
    logic [27:0] seg_out;
    logic        busy;
    logic        done;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;

    proc_num_seg_display #(.DATA_WIDTH(32), .NUM_DIGITS(4)) dut (
        .single_clk (single_clk),
        .reset_n    (reset_n),
        .proc_num   (proc_num),
        .seg_out    (seg_out),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial single_clk = 1'b0;
    always #5 single_clk = ~single_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives a value at a falling edge and samples n falling edges afterwards;
    // optionally swaps proc_num to change_val after change_at samples.
    task automatic applyStimulus(input logic [31:0] value, input int n,
                                 input int change_at, input logic [31:0] change_val,
                                 output int busy_n, output int done_n,
                                 output int done_at, output logic [27:0] first_seg);
        busy_n    = 0;
        done_n    = 0;
        done_at   = 0;
        first_seg = '0;
        proc_num  = value;
        for (int s = 1; s <= n; s++) begin
            @(negedge single_clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_n == 1) begin
                    done_at   = s;
                    first_seg = seg_out;
                end
            end
            if (s == change_at) proc_num = change_val;
        end
    endtask

    int          b_n, d_n, d_at;
    logic [27:0] f_seg;
    int          busy_seen, done_seen;

    initial begin
        reset_n  = 1'b0;
        proc_num = 32'd0;
        repeat (3) @(negedge single_clk);
        checkOutput("reset_seg",  64'(seg_out), 64'({BL, BL, BL, S0}));
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_ovf",  64'(overflow), 64'd0);
        reset_n = 1'b1;

        busy_seen = 0;
        done_seen = 0;
        for (int s = 0; s < 50; s++) begin
            @(negedge single_clk);
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        checkOutput("idle_zero_busy", 64'(busy_seen), 64'd0);
        checkOutput("idle_zero_done", 64'(done_seen), 64'd0);
        checkOutput("idle_zero_seg",  64'(seg_out), 64'({BL, BL, BL, S0}));

        applyStimulus(32'd1234, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("v1234_busy",   64'(b_n), 64'd33);
        checkOutput("v1234_done_n", 64'(d_n), 64'd1);
        checkOutput("v1234_done_at", 64'(d_at), 64'd34);
        checkOutput("v1234_seg",    64'(seg_out), 64'({S1, S2, S3, S4}));
        checkOutput("v1234_ovf",    64'(overflow), 64'd0);

        applyStimulus(32'd7, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("v7_seg",  64'(seg_out), 64'({BL, BL, BL, S7}));
        checkOutput("v7_ovf",  64'(overflow), 64'd0);

        applyStimulus(32'd10000, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("v10000_seg", 64'(seg_out), 64'({DS, DS, DS, DS}));
        checkOutput("v10000_ovf", 64'(overflow), 64'd1);

        applyStimulus(32'd9999, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("v9999_seg", 64'(seg_out), 64'({S9, S9, S9, S9}));
        checkOutput("v9999_ovf", 64'(overflow), 64'd0);

        applyStimulus(32'd42, 80, 11, 32'd305, b_n, d_n, d_at, f_seg);
        checkOutput("v42_first_seg", 64'(f_seg), 64'({BL, BL, S4, S2}));
        checkOutput("v42_first_at",  64'(d_at), 64'd34);
        checkOutput("v42_305_done_n", 64'(d_n), 64'd2);
        checkOutput("v42_305_busy",  64'(b_n), 64'd66);
        checkOutput("v305_seg",      64'(seg_out), 64'({BL, S3, S0, S5}));

        proc_num = 32'd5678;
        repeat (20) @(negedge single_clk);
        checkOutput("v5678_busy_mid", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_seg",  64'(seg_out), 64'({BL, BL, BL, S0}));
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_ovf",  64'(overflow), 64'd0);
        @(negedge single_clk);
        reset_n = 1'b1;
        applyStimulus(32'd5678, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("v5678_busy",    64'(b_n), 64'd33);
        checkOutput("v5678_done_at", 64'(d_at), 64'd34);
        checkOutput("v5678_seg",     64'(seg_out), 64'({S5, S6, S7, S8}));

        applyStimulus(32'hFFFF_FFFF, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("vmax_busy", 64'(b_n), 64'd33);
        checkOutput("vmax_seg",  64'(seg_out), 64'({DS, DS, DS, DS}));
        checkOutput("vmax_ovf",  64'(overflow), 64'd1);

        applyStimulus(32'd0, 40, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("vzero_done_n", 64'(d_n), 64'd1);
        checkOutput("vzero_seg",    64'(seg_out), 64'({BL, BL, BL, S0}));
        checkOutput("vzero_ovf",    64'(overflow), 64'd0);

        applyStimulus(32'd0, 50, 0, 32'd0, b_n, d_n, d_at, f_seg);
        checkOutput("hold_busy", 64'(b_n), 64'd0);
        checkOutput("hold_done", 64'(d_n), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
